clock_div_prog: RTL and testbench
=================================

Name: clock_div_prog

Overview:
- Parametrised, run-time programmable successor to the platform clock divider.
- Divides CLK_I by a divisor D loaded over a simple strobe/ack interface.
- Produces a divided clock, CLK_O, and a CLK_I-domain clock-enable pulse, CE_O, for logic that must stay on CLK_I.
- Sits beside the AHB peripherals; the divisor is written by a bus-side register block.

Parameters:
- CNT_WIDTH, 16, width of divisor and counter; max D = 2^CNT_WIDTH-1.
- RESET_DIV, 2, divisor value after reset; 0 or 1 means bypass.

Ports:
- CLK_I  input  1  source clock.
- RST_I  input  1  asynchronous reset, active-high.
- ENABLE_I  input  1  run request; low stops output at end of current period.
- DIV_I  input  CNT_WIDTH  new divisor value.
- DIV_LOAD_I  input  1  one-cycle strobe; capture DIV_I as pending divisor.
- DIV_ACK_O  output  1  one-cycle pulse when a pending divisor takes effect.
- DIV_O  output  CNT_WIDTH  divisor currently in effect.
- CLK_O  output  1  divided clock.
- CE_O  output  1  CLK_I-domain enable; high in the cycle before each CLK_O rising edge.

Behaviour:
- Reset values: DIV_O=RESET_DIV; counter=0; CLK_O=0; CE_O=0; DIV_ACK_O=0; no pending divisor; running flag=0.
- Divide mode (D>=2):
  - Counter cnt runs 0..D-1 and wraps to 0.
  - High phase H=floor(D/2); CLK_O is registered, 1 while cnt<H, else 0.
  - Period is exactly D CLK_I cycles: D=2 gives 1H/1L, D=3 gives 1H/2L, D=4 gives 2H/2L.
  - Terminal count (TC) is the cycle with cnt==D-1 while running.
  - CE_O=1 exactly in TC cycles, so the next CLK_I rising edge coincides with the CLK_O rising edge.
- Bypass mode (D=0 or D=1):
  - CLK_O = CLK_I gated by an enable register clocked on the falling edge of CLK_I, so output is glitch-free.
  - CE_O=1 every cycle while running.
  - Counter is held at 0.
- Start:
  - Stopped and ENABLE_I sampled high: running=1; next edge cnt=0 and CLK_O=1.
  - First CE_O follows D-1 cycles later.
- Stop:
  - ENABLE_I low takes effect only at TC (bypass: next falling edge); no runt high phase.
  - After stopping: CLK_O=0, cnt=0, CE_O=0.
- Divisor load:
  - DIV_LOAD_I captures DIV_I into a pending register and sets pending.
  - A second load before application overwrites the pending value; only one ack is issued.
  - Pending is applied at the next TC edge, or at the next edge if stopped or in bypass.
  - On application: DIV_O updates, pending clears, DIV_ACK_O=1 for one cycle.
- Simultaneous events:
  - DIV_LOAD_I in the TC cycle of an existing pending: the pending value is applied at that edge; the new value becomes pending for the following TC.
  - Load and stop in the same TC: both take effect.
- Arithmetic:
  - Counter and compares are unsigned CNT_WIDTH.
  - No overflow is possible, since cnt<=D-1<=2^CNT_WIDTH-2.
- Reset mid-period: all state returns to reset values immediately (asynchronous); any pending load is discarded.

Optional Feature:
- Macro: CLOCK_DIV_ODD_DUTY50_EN.
- Defined:
  - For odd D>=3, a falling-edge register delays the end of the high phase by half a CLK_I cycle.
  - High time becomes D/2 CLK_I periods, giving 50% duty; D=3 is high 1.5 cycles, low 1.5 cycles.
  - Even D is unchanged; CE_O timing is unchanged.
- Undefined: no falling-edge logic beyond the bypass gate; odd D has high=floor(D/2), low=ceil(D/2).

Test Plan:
- Reset with RESET_DIV=2, ENABLE_I=1 -> CLK_O toggles every CLK_I cycle; CE_O high every 2nd cycle, aligned before each CLK_O rise; DIV_O=2.
- Load DIV_I=5 mid-period -> DIV_ACK_O single pulse at next TC; thereafter CLK_O high 2 and low 3 cycles; CE_O period 5.
- Load 7 then 9 before a TC -> one ack; DIV_O=9; period 9.
- Load DIV_I=1 -> bypass; CLK_O mirrors CLK_I with no glitch at switchover; CE_O constant 1.
- ENABLE_I low while cnt=1 with D=6 -> CLK_O completes the period and stays 0 from the TC edge; re-enable -> CLK_O high on the next edge.
- RST_I asserted mid-period with a pending load -> outputs reset immediately; DIV_O=RESET_DIV; no ack after release.
- With CLOCK_DIV_ODD_DUTY50_EN, D=3 -> high 1.5 and low 1.5 CLK_I periods.

Source files
------------

// File: rtl/clock_div_prog.sv
// Run-time programmable clock divider: divided clock CLK_O plus a CLK_I-domain enable CE_O.
// Optional macro CLOCK_DIV_ODD_DUTY50_EN stretches the odd-divisor high phase by half a cycle.
module clock_div_prog #(
    parameter int unsigned CNT_WIDTH = 16,
    parameter int unsigned RESET_DIV = 2
) (
    input  logic                 CLK_I,
    input  logic                 RST_I,
    input  logic                 ENABLE_I,
    input  logic [CNT_WIDTH-1:0] DIV_I,
    input  logic                 DIV_LOAD_I,
    output logic                 DIV_ACK_O,
    output logic [CNT_WIDTH-1:0] DIV_O,
    output logic                 CLK_O,
    output logic                 CE_O
);

    localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] DIV_RST = CNT_WIDTH'(RESET_DIV);

    logic [CNT_WIDTH-1:0] div_q, div_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] pval_q, pval_d;
    logic                 pend_q, pend_d;
    logic                 run_q, run_d;
    logic                 clk_q, clk_d;
    logic                 ce_q, ce_d;
    logic                 ack_q, ack_d;
    logic                 gate_q;
    logic                 byp_now, byp_nxt;
    logic                 tc, boundary, apply;
    logic                 div_clk;

    // Posedge state
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            div_q  <= DIV_RST;
            cnt_q  <= '0;
            pval_q <= '0;
            pend_q <= 1'b0;
            run_q  <= 1'b0;
            clk_q  <= 1'b0;
            ce_q   <= 1'b0;
            ack_q  <= 1'b0;
        end else begin
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            pval_q <= pval_d;
            pend_q <= pend_d;
            run_q  <= run_d;
            clk_q  <= clk_d;
            ce_q   <= ce_d;
            ack_q  <= ack_d;
        end
    end

    // A boundary is any edge where a new period may begin: stopped, bypass, or terminal count
    always_comb begin
        byp_now  = (div_q <= ONE);
        tc       = run_q && !byp_now && (cnt_q == (div_q - ONE));
        boundary = !run_q || byp_now || tc;
        apply    = pend_q && boundary;

        div_d  = div_q;
        cnt_d  = '0;
        run_d  = run_q;
        pend_d = pend_q;
        pval_d = pval_q;
        ack_d  = apply;

        if (apply) begin
            div_d  = pval_q;
            pend_d = 1'b0;
        end
        if (DIV_LOAD_I) begin
            pval_d = DIV_I;
            pend_d = 1'b1;
        end

        if (boundary) begin
            run_d = ENABLE_I;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + ONE;
        end

        byp_nxt = (div_d <= ONE);
        clk_d   = run_d && !byp_nxt && (cnt_d < (div_d >> 1));
        ce_d    = run_d && (byp_nxt || (cnt_d == (div_d - ONE)));
    end

    // Bypass gate changes only while CLK_I is low, so the gated clock cannot glitch
    always_ff @(negedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            gate_q <= 1'b0;
        end else begin
            gate_q <= run_q && byp_now;
        end
    end

`ifdef CLOCK_DIV_ODD_DUTY50_EN
    logic ext_q;

    // Half-cycle copy of the high phase, ORed in for odd divisors to reach 50% duty
    always_ff @(negedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            ext_q <= 1'b0;
        end else begin
            ext_q <= clk_q;
        end
    end

    assign div_clk = clk_q | (div_q[0] & ext_q);
`else
    assign div_clk = clk_q;
`endif

    assign CLK_O     = byp_now ? (CLK_I & gate_q) : div_clk;
    assign CE_O      = ce_q;
    assign DIV_ACK_O = ack_q;
    assign DIV_O     = div_q;

endmodule

// File: tb/tb_clock_div_prog.sv
// Self-checking bench for clock_div_prog: directed scenarios with literal pins plus a randomized run
// checked every half cycle against a period-level behavioural model.
module tb_clock_div_prog;

    localparam int unsigned W = 16;

    logic          CLK_I = 1'b0;
    logic          RST_I;
    logic          ENABLE_I;
    logic [W-1:0]  DIV_I;
    logic          DIV_LOAD_I;
    logic          DIV_ACK_O;
    logic [W-1:0]  DIV_O;
    logic          CLK_O;
    logic          CE_O;

    clock_div_prog #(.CNT_WIDTH(W), .RESET_DIV(2)) dut (
        .CLK_I      (CLK_I),
        .RST_I      (RST_I),
        .ENABLE_I   (ENABLE_I),
        .DIV_I      (DIV_I),
        .DIV_LOAD_I (DIV_LOAD_I),
        .DIV_ACK_O  (DIV_ACK_O),
        .DIV_O      (DIV_O),
        .CLK_O      (CLK_O),
        .CE_O       (CE_O)
    );

    always #5 CLK_I = ~CLK_I;

    int errors = 0;
    int checks = 0;

    // Model: divisor in effect, position within the current period, run flag, pending load
    int m_div  = 2;
    int m_pos  = 0;
    int m_pval = 0;
    bit m_run  = 1'b0;
    bit m_pend = 1'b0;
    bit m_ack  = 1'b0;
    bit m_gate = 1'b0;
`ifdef CLOCK_DIV_ODD_DUTY50_EN
    bit m_ext  = 1'b0;
`endif

    // Observations of the last rising-edge sample
    bit obs_clk;
    bit obs_ce;
    bit obs_ack;
    int ack_seen;
    int hi_seen;
    int ce_seen;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_bypass();
        return m_div < 2;
    endfunction

    function automatic bit m_high();
        return m_run && !m_bypass() && (m_pos < m_div / 2);
    endfunction

    function automatic bit m_ce();
        return m_run && (m_bypass() || (m_pos == m_div - 1));
    endfunction

    function automatic bit m_clk_rise();
        if (m_bypass()) return m_gate;
`ifdef CLOCK_DIV_ODD_DUTY50_EN
        return m_high() || ((m_div % 2 == 1) && m_ext);
`else
        return m_high();
`endif
    endfunction

    function automatic bit m_clk_fall();
        if (m_bypass()) return 1'b0;
        return m_high();
    endfunction

    task automatic model_rise();
        bit period_end;
        period_end = !m_run || m_bypass() || (m_pos == m_div - 1);
        m_ack = 1'b0;
        if (m_pend && period_end) begin
            m_div  = m_pval;
            m_pend = 1'b0;
            m_ack  = 1'b1;
        end
        if (period_end) begin
            m_run = ENABLE_I;
            m_pos = 0;
        end else begin
            m_pos++;
        end
        if (DIV_LOAD_I) begin
            m_pend = 1'b1;
            m_pval = int'(DIV_I);
        end
    endtask

    task automatic model_fall();
        m_gate = m_run && m_bypass();
`ifdef CLOCK_DIV_ODD_DUTY50_EN
        m_ext  = m_high();
`endif
    endtask

    task automatic model_reset();
        m_div  = 2;
        m_pos  = 0;
        m_run  = 1'b0;
        m_pend = 1'b0;
        m_ack  = 1'b0;
        m_gate = 1'b0;
`ifdef CLOCK_DIV_ODD_DUTY50_EN
        m_ext  = 1'b0;
`endif
    endtask

    // One CLK_I cycle; the model is compared after both edges
    task automatic cycle();
        @(posedge CLK_I);
        model_rise();
        #1;
        check("clk_rise", int'(CLK_O), int'(m_clk_rise()));
        check("ce", int'(CE_O), int'(m_ce()));
        check("ack", int'(DIV_ACK_O), int'(m_ack));
        check("div", int'(DIV_O), m_div);
        obs_clk = CLK_O;
        obs_ce  = CE_O;
        obs_ack = DIV_ACK_O;
        if (DIV_ACK_O) ack_seen++;
        if (CLK_O) hi_seen++;
        if (CE_O) ce_seen++;
        @(negedge CLK_I);
        model_fall();
        #1;
        check("clk_fall", int'(CLK_O), int'(m_clk_fall()));
    endtask

    // Asynchronous reset while CLK_I is low; outputs must clear without an edge
    task automatic apply_reset();
        RST_I      = 1'b1;
        DIV_LOAD_I = 1'b0;
        #1;
        check("rst_clk", int'(CLK_O), 0);
        check("rst_ce", int'(CE_O), 0);
        check("rst_ack", int'(DIV_ACK_O), 0);
        check("rst_div", int'(DIV_O), 2);
        model_reset();
        #1;
        RST_I = 1'b0;
    endtask

    task automatic wait_tc();
        int n = 0;
        while (!obs_ce && n < 30) begin
            cycle();
            n++;
        end
        if (!obs_ce) begin
            checks++;
            errors++;
            $display("FAIL wait_tc: no CE_O within %0d cycles", n);
        end
    endtask

    task automatic load(input int value);
        DIV_I      = W'(value);
        DIV_LOAD_I = 1'b1;
        cycle();
        DIV_LOAD_I = 1'b0;
    endtask

    initial begin
        RST_I      = 1'b0;
        ENABLE_I   = 1'b0;
        DIV_I      = '0;
        DIV_LOAD_I = 1'b0;
        #2;
        apply_reset();

        // D=2 from reset: 1H/1L, CE_O in every second cycle just before each rise
        ENABLE_I = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("pin_d2_clk", int'(obs_clk), (i % 2 == 0) ? 1 : 0);
            check("pin_d2_ce", int'(obs_ce), (i % 2 == 1) ? 1 : 0);
        end
        cycle();

        // Mid-period load of 5
        ack_seen = 0;
        load(5);
        repeat (12) cycle();
        check("pin_d5_ack", ack_seen, 1);
        check("pin_d5_div", int'(DIV_O), 5);
        hi_seen = 0;
        ce_seen = 0;
        repeat (10) cycle();
        check("pin_d5_high", hi_seen, 4);
        check("pin_d5_ce", ce_seen, 2);

        // Two loads before one terminal count produce a single ack
        wait_tc();
        ack_seen = 0;
        load(7);
        load(9);
        repeat (12) cycle();
        check("pin_d9_ack", ack_seen, 1);
        check("pin_d9_div", int'(DIV_O), 9);
        hi_seen = 0;
        ce_seen = 0;
        repeat (18) cycle();
        check("pin_d9_high", hi_seen, 8);
        check("pin_d9_ce", ce_seen, 2);

        // Bypass
        load(1);
        repeat (12) cycle();
        hi_seen = 0;
        ce_seen = 0;
        repeat (6) cycle();
        check("pin_byp_div", int'(DIV_O), 1);
        check("pin_byp_high", hi_seen, 6);
        check("pin_byp_ce", ce_seen, 6);

        // D=6, stop requested at cnt=1, then restart
        load(6);
        cycle();
        check("pin_d6_ack", int'(obs_ack), 1);
        check("pin_d6_start", int'(obs_clk), 1);
        cycle();
        ENABLE_I = 1'b0;
        hi_seen  = 0;
        ce_seen  = 0;
        repeat (4) cycle();
        check("pin_stop_high", hi_seen, 1);
        check("pin_stop_ce", ce_seen, 1);
        hi_seen = 0;
        ce_seen = 0;
        repeat (5) cycle();
        check("pin_stopped_high", hi_seen, 0);
        check("pin_stopped_ce", ce_seen, 0);
        ENABLE_I = 1'b1;
        cycle();
        check("pin_restart", int'(obs_clk), 1);

        // Reset with a load pending discards it
        load(3);
        ENABLE_I = 1'b0;
        apply_reset();
        ack_seen = 0;
        hi_seen  = 0;
        repeat (10) cycle();
        check("pin_rst_noack", ack_seen, 0);
        check("pin_rst_div", int'(DIV_O), 2);
        check("pin_rst_high", hi_seen, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            ENABLE_I   = ($urandom_range(0, 99) < 85);
            DIV_LOAD_I = ($urandom_range(0, 99) < 8);
            if ($urandom_range(0, 4) == 0) DIV_I = W'($urandom_range(0, 1));
            else DIV_I = W'($urandom_range(2, 12));
            if ($urandom_range(0, 999) < 3) apply_reset();
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
